dense_mac_sequencer: RTL and testbench

Initiator and controller for one fixed-point multiply-accumulate dot-product unit. For each output neuron, the block does four things in order:
- fetches NUM_INPUTS activation/weight pairs from synchronous RAMs,
- drives the MAC unit's run/clear/reset controls,
- captures the biased accumulator result and applies optional ReLU,
- writes the result to the output activation buffer.

It sits between the layer-level controller (start/done) and one MAC instance, forming one fully-connected layer stage.

---
 rtl/cnn_pkg.sv | 8 +
 rtl/dense_mac_sequencer_if.sv | 33 +++
 rtl/fixed_relu.sv | 10 +
 rtl/dense_mac_sequencer.sv | 89 ++++++++
 tb/tb_dense_mac_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and sequencer state encoding for the CNN layer stages.
package cnn_pkg;
    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_FRACTION_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH     = 10;
    localparam int MEM_RD_LATENCY         = 1;
    typedef enum logic [2:0] {IDLE, INIT, FETCH, DRAIN, WRITE, CLEAR, DONE} seq_state_t;
endpackage

// File: rtl/dense_mac_sequencer_if.sv
// dense_mac_sequencer_if: layer control, memory, MAC and output-buffer signals of one dense stage.
interface dense_mac_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic                  relu_en;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  mac_reset;
    logic                  mac_run;
    logic                  mac_clear;
    logic [DATA_WIDTH-1:0] mac_result;
    logic [ADDR_WIDTH-1:0] mac_address;
    logic                  out_we;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  sync_err;
    modport master (
        input  start, relu_en, mac_result, mac_address,
        output busy, done, mem_rd_en, in_addr, w_addr, b_addr,
               mac_reset, mac_run, mac_clear, out_we, out_addr, out_data, sync_err
    );
    modport slave (
        output start, relu_en, mac_result, mac_address,
        input  busy, done, mem_rd_en, in_addr, w_addr, b_addr,
               mac_reset, mac_run, mac_clear, out_we, out_addr, out_data, sync_err
    );
endinterface

// File: rtl/fixed_relu.sv
// fixed_relu: combinational ReLU clamp for signed fixed-point words, bypassed when i_en is low.
module fixed_relu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    assign o_data = (i_en && i_data[DATA_WIDTH-1]) ? '0 : i_data;
endmodule

// File: rtl/dense_mac_sequencer.sv
// dense_mac_sequencer: walks every neuron of a dense layer, feeding one MAC from the
// activation/weight RAMs and writing each biased, optionally rectified result out.
module dense_mac_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int FRACTION_WIDTH = DEFAULT_FRACTION_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int NUM_INPUTS     = 16,
    parameter int NUM_OUTPUTS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dense_mac_sequencer_if.master bus
);
    if (FRACTION_WIDTH >= DATA_WIDTH || NUM_INPUTS < 1 || NUM_OUTPUTS < 1 ||
        NUM_INPUTS * NUM_OUTPUTS > 2 ** ADDR_WIDTH || MEM_RD_LATENCY != 1) begin : g_bad_cfg
        $error("dense_mac_sequencer: unsupported configuration");
    end
    seq_state_t            r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_n, r_i;
    logic                  r_relu, r_run, r_sync_err;
    logic [DATA_WIDTH-1:0] w_relu_out;
    logic                  w_last_i, w_last_n, w_busy, w_write;
    assign w_last_i = r_i == ADDR_WIDTH'(NUM_INPUTS - 1);
    assign w_last_n = r_n == ADDR_WIDTH'(NUM_OUTPUTS - 1);
    assign w_busy   = r_state != IDLE && r_state != DONE;
    assign w_write  = r_state == WRITE;
    fixed_relu #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
        .i_en  (r_relu),
        .i_data(bus.mac_result),
        .o_data(w_relu_out)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_i        <= '0;
            r_relu     <= 1'b0;
            r_run      <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // run trails the read strobe by the RAM latency so the MAC sees valid data
            r_run   <= bus.mem_rd_en;
            if (r_state == IDLE && bus.start) begin
                r_relu <= bus.relu_en;
                r_n    <= '0;
                r_i    <= '0;
            end
            if (r_state == FETCH && !w_last_i)
                r_i <= r_i + 1'b1;
            if (r_state == CLEAR) begin
                r_i <= '0;
                if (!w_last_n)
                    r_n <= r_n + 1'b1;
            end
            if (r_state == INIT)
                r_sync_err <= 1'b0;
            else if (w_write && bus.mac_address != r_n)
                r_sync_err <= 1'b1;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? INIT : IDLE;
            INIT:    w_next = FETCH;
            FETCH:   w_next = w_last_i ? DRAIN : FETCH;
            DRAIN:   w_next = WRITE;
            WRITE:   w_next = CLEAR;
            CLEAR:   w_next = w_last_n ? DONE : FETCH;
            default: w_next = IDLE;
        endcase
        bus.busy      = w_busy;
        bus.done      = r_state == DONE;
        bus.mem_rd_en = r_state == FETCH;
        bus.in_addr   = r_state == FETCH ? r_i : '0;
        bus.w_addr    = r_state == FETCH ? ADDR_WIDTH'(r_n * NUM_INPUTS + r_i) : '0;
        bus.b_addr    = w_busy ? r_n : '0;
        bus.mac_reset = r_state == INIT;
        bus.mac_run   = r_run;
        bus.mac_clear = r_state == CLEAR;
        bus.out_we    = w_write;
        bus.out_addr  = w_write ? r_n : '0;
        bus.out_data  = w_write ? w_relu_out : '0;
        bus.sync_err  = r_sync_err;
    end
endmodule

// File: tb/tb_dense_mac_sequencer.sv
// tb_dense_mac_sequencer: drives the sequencer against RAM and MAC models and checks
// timing, addresses and results against a dot-product reference.
module tb_dense_mac_sequencer;
    localparam int N   = 4;
    localparam int M   = 2;
    localparam int LEN = 20;
    localparam int D   = 2 + M * (N + 3);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;

    dense_mac_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();
    dense_mac_sequencer #(
        .DATA_WIDTH(16), .FRACTION_WIDTH(8), .ADDR_WIDTH(10),
        .NUM_INPUTS(N), .NUM_OUTPUTS(M)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    logic signed [15:0] act_mem [0:1023];
    logic signed [15:0] wgt_mem [0:1023];
    logic signed [15:0] bias_mem[0:1023];
    logic signed [15:0] act_q, wgt_q, bias_q, acc;
    logic [9:0]         mac_addr_q;
    bit                 addr_stuck = 0;

    always_ff @(posedge clk) begin
        if (bus.mem_rd_en) begin
            act_q <= act_mem[bus.in_addr];
            wgt_q <= wgt_mem[bus.w_addr];
        end
        bias_q <= bias_mem[bus.b_addr];
        if (reset || bus.mac_reset) begin
            acc        <= '0;
            mac_addr_q <= '0;
        end else if (bus.mac_clear) begin
            acc        <= '0;
            mac_addr_q <= mac_addr_q + 10'd1;
        end else if (bus.mac_run)
            acc <= acc + 16'((int'(act_q) * int'(wgt_q)) >>> 8);
    end
    assign bus.mac_result  = acc + bias_q;
    assign bus.mac_address = addr_stuck ? 10'd0 : mac_addr_q;

    logic       tr_busy[LEN], tr_done[LEN], tr_rd[LEN], tr_run[LEN], tr_clr[LEN];
    logic       tr_mrst[LEN], tr_we[LEN], tr_err[LEN];
    logic [9:0] tr_in[LEN], tr_w[LEN], tr_b[LEN], tr_oa[LEN];
    logic [15:0] tr_od[LEN];

    function automatic logic [15:0] ref_out(int n, logic relu);
        int s = int'(bias_mem[n]);
        logic [15:0] r;
        for (int k = 0; k < N; k++)
            s += (int'(act_mem[k]) * int'(wgt_mem[n * N + k])) >>> 8;
        r = 16'(s);
        return (relu && r[15]) ? 16'h0000 : r;
    endfunction

    function automatic int wr_cycle(int n);
        return 3 + N + n * (N + 3);
    endfunction

    function automatic bit is_fetch(int c);
        int rel = c - 2;
        return rel >= 0 && rel / (N + 3) < M && rel % (N + 3) < N;
    endfunction

    task automatic load(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b0,
                        input logic [15:0] b1);
        for (int k = 0; k < 1024; k++) begin
            act_mem[k] = a;
            wgt_mem[k] = w;
            bias_mem[k] = 16'h0000;
        end
        bias_mem[0] = b0;
        bias_mem[1] = b1;
    endtask

    task automatic run_layer(input logic relu, input int sp, input int rc);
        for (int c = 0; c < LEN; c++) begin
            @(negedge clk);
            tr_busy[c] = bus.busy;   tr_done[c] = bus.done;     tr_rd[c] = bus.mem_rd_en;
            tr_run[c]  = bus.mac_run; tr_clr[c] = bus.mac_clear; tr_mrst[c] = bus.mac_reset;
            tr_we[c]   = bus.out_we;  tr_err[c] = bus.sync_err;  tr_in[c] = bus.in_addr;
            tr_w[c]    = bus.w_addr;  tr_b[c]   = bus.b_addr;    tr_oa[c] = bus.out_addr;
            tr_od[c]   = bus.out_data;
            bus.start   = (c == 0 || c == sp);
            bus.relu_en = (c == 0) ? relu : ~relu;
            reset       = (c == rc);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.relu_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.mac_run, bus.mac_clear, bus.mac_reset,
             bus.out_we, bus.sync_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {bus.busy, bus.done,
                     bus.mem_rd_en, bus.mac_run, bus.mac_clear, bus.mac_reset, bus.out_we, bus.sync_err});
        end
        n_checks++;
        if ({bus.in_addr, bus.w_addr, bus.b_addr, bus.out_addr, bus.out_data} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {bus.in_addr, bus.w_addr, bus.b_addr, bus.out_addr, bus.out_data});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input string tag, input int sp);
        load(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        run_layer(1'b0, sp, -1);
        for (int c = 0; c < LEN; c++) begin
            n_checks++;
            if (tr_busy[c] !== (c >= 1 && c < D)) begin
                n_fail++;
                $display("FAIL %s_busy cycle %0d: got %b expected %b", tag, c, tr_busy[c], c >= 1 && c < D);
            end
            n_checks++;
            if (tr_done[c] !== (c == D)) begin
                n_fail++;
                $display("FAIL %s_done cycle %0d: got %b expected %b", tag, c, tr_done[c], c == D);
            end
            n_checks++;
            if (tr_we[c] !== (c == wr_cycle(0) || c == wr_cycle(1))) begin
                n_fail++;
                $display("FAIL %s_we cycle %0d: got %b", tag, c, tr_we[c]);
            end
            n_checks++;
            if (tr_err[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_sync_err cycle %0d: got %b expected 0", tag, c, tr_err[c]);
            end
        end
        for (int n = 0; n < M; n++) begin
            n_checks++;
            if (tr_od[wr_cycle(n)] !== 16'h0200 || tr_oa[wr_cycle(n)] !== 10'(n)) begin
                n_fail++;
                $display("FAIL %s_write%0d: got %h@%0d expected 0200@%0d", tag, n,
                         tr_od[wr_cycle(n)], tr_oa[wr_cycle(n)], n);
            end
        end
    endtask

    task automatic test_relu;
        load(16'h0100, 16'hFF80, 16'h0000, 16'h0000);
        for (int r = 1; r >= 0; r--) begin
            run_layer(r[0], -1, -1);
            for (int n = 0; n < M; n++) begin
                n_checks++;
                if (tr_od[wr_cycle(n)] !== (r ? 16'h0000 : 16'hFE00)) begin
                    n_fail++;
                    $display("FAIL relu%0d_write%0d: got %h expected %h", r, n,
                             tr_od[wr_cycle(n)], r ? 16'h0000 : 16'hFE00);
                end
            end
        end
    endtask

    task automatic test_bias_clear;
        load(16'h0100, 16'h0080, 16'h0000, 16'h0100);
        run_layer(1'b0, -1, -1);
        n_checks++;
        if (tr_od[wr_cycle(0)] !== 16'h0200 || tr_od[wr_cycle(1)] !== 16'h0300) begin
            n_fail++;
            $display("FAIL bias_writes: got %h %h expected 0200 0300", tr_od[wr_cycle(0)], tr_od[wr_cycle(1)]);
        end
        for (int c = 0; c < LEN; c++) begin
            n_checks++;
            if (tr_clr[c] !== (c == 8 || c == 15) || tr_mrst[c] !== (c == 1) || (tr_clr[c] && tr_run[c])) begin
                n_fail++;
                $display("FAIL mac_ctrl cycle %0d: got clr=%b rst=%b run=%b", c, tr_clr[c], tr_mrst[c], tr_run[c]);
            end
        end
    endtask

    task automatic test_addresses;
        int k = 0;
        load(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        run_layer(1'b0, -1, -1);
        for (int c = 0; c < LEN; c++) begin
            n_checks++;
            if (tr_rd[c] !== is_fetch(c) || tr_run[c] !== (c > 0 && is_fetch(c - 1))) begin
                n_fail++;
                $display("FAIL rd_run cycle %0d: got rd=%b run=%b", c, tr_rd[c], tr_run[c]);
            end
            if (is_fetch(c)) begin
                n_checks++;
                if (tr_w[c] !== 10'(k) || tr_in[c] !== 10'(k % N)) begin
                    n_fail++;
                    $display("FAIL fetch_addr cycle %0d: got w=%0d in=%0d expected w=%0d in=%0d",
                             c, tr_w[c], tr_in[c], k, k % N);
                end
                k++;
            end
            n_checks++;
            if (tr_b[c] !== ((c >= 1 && c < D) ? 10'((c - 2) / (N + 3)) : 10'd0)) begin
                n_fail++;
                $display("FAIL b_addr cycle %0d: got %0d", c, tr_b[c]);
            end
        end
        n_checks++;
        if (k !== N * M) begin
            n_fail++;
            $display("FAIL fetch_count: got %0d expected %0d", k, N * M);
        end
    endtask

    task automatic test_reset_abort;
        bit any_done = 0;
        load(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        run_layer(1'b0, -1, 5);
        n_checks++;
        if ({tr_busy[6], tr_done[6], tr_rd[6], tr_run[6], tr_clr[6], tr_mrst[6], tr_we[6], tr_err[6],
             tr_in[6], tr_w[6], tr_b[6], tr_oa[6], tr_od[6]} !== 64'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b rd=%b run=%b w=%0d b=%0d expected all 0",
                     tr_busy[6], tr_rd[6], tr_run[6], tr_w[6], tr_b[6]);
        end
        for (int c = 5; c < LEN; c++) any_done |= tr_done[c] | tr_we[c];
        n_checks++;
        if (any_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %b expected 0", any_done);
        end
        test_basic("rerun", -1);
    endtask

    task automatic test_sync_err;
        load(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        addr_stuck = 1;
        run_layer(1'b0, -1, -1);
        for (int c = 0; c < LEN; c++) begin
            if (c == 14) continue;
            n_checks++;
            if (tr_err[c] !== (c >= 15)) begin
                n_fail++;
                $display("FAIL sync_set cycle %0d: got %b expected %b", c, tr_err[c], c >= 15);
            end
        end
        addr_stuck = 0;
        run_layer(1'b0, -1, -1);
        for (int c = 0; c < LEN; c++) begin
            if (c == 1) continue;
            n_checks++;
            if (tr_err[c] !== (c == 0)) begin
                n_fail++;
                $display("FAIL sync_clear cycle %0d: got %b expected %b", c, tr_err[c], c == 0);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            logic relu = 1'($urandom);
            for (int k = 0; k < N * M; k++) begin
                act_mem[k] = 16'($urandom);
                wgt_mem[k] = 16'($urandom);
            end
            for (int n = 0; n < M; n++) bias_mem[n] = 16'($urandom);
            run_layer(relu, -1, -1);
            for (int n = 0; n < M; n++) begin
                n_checks++;
                if (tr_we[wr_cycle(n)] !== 1'b1 || tr_od[wr_cycle(n)] !== ref_out(n, relu)) begin
                    n_fail++;
                    $display("FAIL random%0d_write%0d: got we=%b %h expected %h", it, n,
                             tr_we[wr_cycle(n)], tr_od[wr_cycle(n)], ref_out(n, relu));
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.relu_en = 1'b0;
        test_reset();
        test_basic("basic", -1);
        test_relu();
        test_bias_clear();
        test_addresses();
        test_reset_abort();
        test_basic("start_ignored", 4);
        test_sync_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
